fp_vector_div_issuer: RTL and testbench
=======================================

Name: fp_vector_div_issuer

Overview:
- Initiator side of the fixed-latency FP divider interface.
- Divides an N-element vector (e.g. LCMV weight normalisation by a scalar denominator) by one latched divisor.
- Accepts elements on a valid/ready stream and issues them into the divider, which has no backpressure.
- Collects results in an internal FIFO, in order. A credit counter ensures no divider result is ever dropped while downstream stalls.

Parameters:
WIDTH, 32, float word width (matches divider)
LATENCY, 28, divider latency in cycles (informational; correctness must not depend on it)
DEPTH, 32, result FIFO depth (power of 2); DEPTH >= LATENCY+2 sustains 1 element/cycle
LEN_W, 10, width of vector length field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a vector operation; sampled only in IDLE
len  in  LEN_W  element count, latched on start
divisor  in  WIDTH  divisor, latched on start
in_data  in  WIDTH  dividend element
in_valid  in  1  in_data valid
in_ready  out  1  element accepted when in_valid && in_ready
out_data  out  WIDTH  quotient (FIFO head)
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts
out_last  out  1  marks the len-th quotient
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at completion
err  out  1  sticky: div_valid with nothing in flight, or FIFO push while full
div_a  out  WIDTH  to divider a (= in_data)
div_b  out  WIDTH  to divider b (= latched divisor)
div_ready  out  1  to divider ready (issue strobe)
div_o  in  WIDTH  divider result
div_valid  in  1  divider result valid

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, done=0, err=0, div_ready=0, out_data=0. All counters and the FIFO are cleared. State is IDLE.
- Shared rst with the divider, so a reset mid-operation aborts cleanly with no restart or replay.
- States:
  - IDLE: on start with len!=0, latch len and divisor, then go to RUN. On start with len==0, go to FIN.
  - RUN: issues elements. Go to DRAIN in the cycle after issued_cnt reaches len.
  - DRAIN: no issue. Go to FIN when popped_cnt==len (last pop handshake).
  - FIN: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Credit rule:
  - in_ready = (state==RUN) && (issued_cnt < len) && (in_flight + fifo_count < DEPTH).
  - Uses registered values; a same-cycle pop gives no credit.
- Issue: div_ready = in_valid && in_ready, combinational. div_a = in_data, div_b = latched divisor. Each issue increments issued_cnt and in_flight.
- Result capture:
  - div_valid pushes div_o into the FIFO and decrements in_flight.
  - Issue and result in the same cycle leave in_flight unchanged.
  - div_valid while in_flight==0, or a push while the FIFO is full: set err, drop the word, counters unchanged.
- Output:
  - out_data and out_valid reflect the FIFO head.
  - A pop occurs on out_valid && out_ready and increments popped_cnt.
  - out_last = out_valid && (popped_cnt == len-1).
  - Push and pop in the same cycle leave fifo_count unchanged. Pushing into an empty FIFO gives out_valid=1 the next cycle, so there is no combinational path div_valid -> out_valid.
- Ordering: results leave in issue order (divider is in-order).
- Widths: issued_cnt and popped_cnt are LEN_W bits. in_flight and fifo_count are clog2(DEPTH)+1 bits.
- Throughput: with out_ready=1, in_valid=1 and DEPTH >= LATENCY+2, one issue per cycle, no bubbles.
- Latency: issue to out_valid is LATENCY+1 cycles.
- err clears only on rst.

Test Plan:
- Behavioural divider model, latency 28. start, len=4, divisor=0x40000000 (2.0); in_data 0x40C00000, 0x3F800000, 0x40800000, 0x00000000 back-to-back; out_ready=1 -> outputs 0x40400000, 0x3F000000, 0x40000000, 0x00000000 in order. First out_valid 29 cycles after the first issue. out_last on the 4th output; done pulses once; busy falls with done.
- Full rate: len=100, in_valid=1, out_ready=1, DEPTH=32 -> in_ready held high for 100 consecutive cycles and 100 consecutive output cycles.
- Backpressure: len=64, out_ready=0 throughout -> exactly 32 issues, then in_ready=0. FIFO full, err=0. Release out_ready -> all 64 quotients delivered in order; done once.
- len=0 start -> no div_ready; done pulses 2 cycles after start; no out_valid.
- Protocol: start while busy is ignored (latched len unchanged). Inject div_valid with in_flight==0 -> err=1 and stays set, no FIFO push.
- Reset mid-DRAIN with 10 results in flight/FIFO -> next cycle all outputs at reset values, state IDLE. A new start with len=2 completes correctly.

Source files
------------

// File: rtl/fp_vector_div_issuer.sv
// Issues a vector of dividends into a fixed-latency, non-stalling FP divider against one latched
// divisor, and buffers the quotients in an in-order FIFO guarded by a credit count.
module fp_vector_div_issuer #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 28,
   parameter int DEPTH   = 32,
   parameter int LEN_W   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] divisor,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_ready,
   input  logic [WIDTH-1:0] div_o,
   input  logic             div_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q, issued_cnt, popped_cnt;
   logic [WIDTH-1:0] divisor_q;
   logic [CW-1:0]    in_flight, fifo_count;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             issue, push, pop, fifo_full, last_pop;

   // A smaller FIFO than the divider pipeline only lowers throughput; ordering and no-drop still hold.
   if (DEPTH < LATENCY + 2) begin : g_rate_limited
   end

   // Every issued element reserves a FIFO slot, so a result can always be stored when it arrives.
   assign in_ready  = (state == RUN) && (issued_cnt < len_q) &&
                      (SW'(in_flight) + SW'(fifo_count) < SW'(DEPTH));
   assign issue     = in_valid && in_ready;
   assign div_ready = issue;
   assign div_a     = in_data;
   assign div_b     = divisor_q;

   assign fifo_full = (fifo_count == CW'(DEPTH));
   assign push      = div_valid && (in_flight != '0) && !fifo_full;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign last_pop  = (popped_cnt == LEN_W'(len_q - 1'b1));
   assign out_last  = out_valid && last_pop;

   assign busy = (state != IDLE);
   assign done = (state == FIN);

   always_comb begin
      // NOTE: default assigned first so no branch leaves state_nx unassigned (which would infer a latch).
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (len == '0) ? FIN : RUN;
         RUN:     if (issued_cnt == len_q) state_nx = DRAIN;
         DRAIN:   if ((popped_cnt == len_q) || (pop && last_pop)) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         len_q      <= '0;
         divisor_q  <= '0;
         issued_cnt <= '0;
         popped_cnt <= '0;
         in_flight  <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         err        <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            len_q      <= len;
            divisor_q  <= divisor;
            issued_cnt <= '0;
            popped_cnt <= '0;
         end else begin
            if (issue) issued_cnt <= issued_cnt + 1'b1;
            if (pop)   popped_cnt <= popped_cnt + 1'b1;
         end
         in_flight  <= in_flight + CW'(issue) - CW'(push);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // A result that is unexpected or has no room is dropped and flagged until reset.
         if (div_valid && !push) err <= 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; out_data is masked by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= div_o;
   end

endmodule

// File: tb/tb_fp_vector_div_issuer.sv
// Self-checking bench: behavioural 28-cycle divider, quotient scoreboard and directed/random vectors.
module tb_fp_vector_div_issuer;

   localparam int WIDTH = 32;
   localparam int LAT   = 28;
   localparam int DEPTH = 32;
   localparam int LEN_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] div_a;
   logic [WIDTH-1:0] div_b;
   logic             div_ready;
   logic [WIDTH-1:0] div_o;
   logic             div_valid;
   logic             inj = 1'b0;

   fp_vector_div_issuer #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .divisor(divisor),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .err(err),
      .div_a(div_a), .div_b(div_b), .div_ready(div_ready), .div_o(div_o), .div_valid(div_valid)
   );

   always #5 clk = ~clk;

   // Quotient for power-of-two divisors: exponent shift, sign xor, zero stays zero.
   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      int e;
      if (a[30:0] == 31'h0) return {a[31] ^ b[31], 31'h0};
      e = int'(a[30:23]) - (int'(b[30:23]) - 127);
      return {a[31] ^ b[31], e[7:0], a[22:0]};
   endfunction

   function automatic logic [31:0] rand_float();
      logic [7:0]  e;
      logic [22:0] m;
      e = 8'($urandom_range(230, 20));
      m = 23'($urandom);
      return {1'($urandom_range(1, 0)), e, m};
   endfunction

   // Behavioural divider: fixed latency, no backpressure, cleared by the shared reset.
   logic [31:0] pd [LAT];
   logic        pv [LAT];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= div_ready;
         pd[0] <= fdiv(div_a, div_b);
      end
   end
   assign div_valid = pv[LAT-1] | inj;
   assign div_o     = pv[LAT-1] ? pd[LAT-1] : 32'h0;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] exp_q [$];
   logic [31:0] cur_div;
   logic [31:0] src [4];
   int          vec_len, pop_cnt, issue_cnt, done_cnt, done_cyc, start_cyc;
   int          first_issue, first_ov, run_ir, max_ir, run_pop, max_pop;
   bit          took;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"},  in_ready,  0);
      check({pfx, "_out_valid"}, out_valid, 0);
      check({pfx, "_out_last"},  out_last,  0);
      check({pfx, "_busy"},      busy,      0);
      check({pfx, "_done"},      done,      0);
      check({pfx, "_err"},       err,       0);
      check({pfx, "_div_ready"}, div_ready, 0);
      check({pfx, "_out_data"},  out_data,  0);
   endtask

   // Observes one cycle's handshakes (inputs settled, before the next rising edge).
   task automatic monitor();
      took = 1'b0;
      cyc++;
      if (rst) return;
      check("div_ready", div_ready, in_valid && in_ready);
      if (in_valid && in_ready) begin
         took = 1'b1;
         issue_cnt++;
         if (first_issue < 0) first_issue = cyc;
         exp_q.push_back(fdiv(in_data, cur_div));
         check("div_a", div_a, in_data);
         check("div_b", div_b, cur_div);
      end
      run_ir = in_ready ? run_ir + 1 : 0;
      if (run_ir > max_ir) max_ir = run_ir;
      if (out_valid && first_ov < 0) first_ov = cyc;
      check("out_last", out_last, out_valid && (pop_cnt == vec_len - 1));
      if (out_valid && out_ready) begin
         check("out_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
         pop_cnt++;
         run_pop++;
      end else begin
         run_pop = 0;
      end
      if (run_pop > max_pop) max_pop = run_pop;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_with_done", busy, 1);
      end
   endtask

   task automatic tick();
      #1;
      monitor();
      @(negedge clk);
   endtask

   // One vector operation. stall: cycles with out_ready forced low; restart_at: cycle of an extra
   // start while busy; abort_at: cycle at which reset is applied mid-operation.
   task automatic run_vec(input int n, input logic [31:0] dv, input int vpct, input int rpct,
                          input bit directed, input int stall, input int restart_at, input int abort_at);
      int idx;
      int guard;
      idx = 0; guard = 0;
      vec_len = n; cur_div = dv; pop_cnt = 0; issue_cnt = 0; done_cnt = 0; done_cyc = -1;
      first_issue = -1; first_ov = -1; run_ir = 0; max_ir = 0; run_pop = 0; max_pop = 0;
      start = 1'b1; len = LEN_W'(n); divisor = dv; in_valid = 1'b0; out_ready = 1'b0;
      start_cyc = cyc + 1;
      tick();
      start = 1'b0; len = LEN_W'($urandom); divisor = $urandom;
      while (done_cnt == 0 && guard < 4000) begin
         if (guard == abort_at) begin
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            tick();
            rst = 1'b0;
            exp_q.delete();
            check_reset_outputs("mid_reset");
            return;
         end
         if (stall > 0 && guard == stall) begin
            check("bp_issues", issue_cnt, DEPTH);
            check("bp_in_ready", in_ready, 0);
            check("bp_full_out_valid", out_valid, 1);
            check("bp_err", err, 0);
         end
         start = (guard == restart_at);
         if (start) len = 7;
         in_valid  = (idx < n || n == 0) && ($urandom_range(99, 0) < vpct);
         in_data   = (directed && idx < 4) ? src[idx] : rand_float();
         out_ready = (guard >= stall) && ($urandom_range(99, 0) < rpct);
         tick();
         start = 1'b0;
         if (took) idx++;
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("vec_timeout", guard < 4000, 1);
      check("done_once", done_cnt, 1);
      check("issues", issue_cnt, n);
      check("pops", pop_cnt, n);
      check("scoreboard_empty", exp_q.size(), 0);
      check("err_clear", err, 0);
      check("busy_after_done", busy, 0);
      check("done_after", done, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      src[0] = 32'h40C00000; src[1] = 32'h3F800000; src[2] = 32'h40800000; src[3] = 32'h00000000;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Directed: 6/2, 1/2, 4/2, 0/2 back-to-back.
      run_vec(4, 32'h40000000, 100, 100, 1'b1, 0, -1, -1);
      check("lat_issue_to_out", first_ov - first_issue, LAT + 1);
      check("directed_q0", fdiv(src[0], 32'h40000000), 32'h40400000);

      // Full rate.
      run_vec(100, 32'h40000000, 100, 100, 1'b0, 0, -1, -1);
      check("fullrate_in_ready_run", max_ir, 100);
      check("fullrate_out_run", max_pop, 100);

      // Backpressure: out_ready low for 100 cycles, then released.
      run_vec(64, 32'h40000000, 100, 100, 1'b0, 100, -1, -1);

      // Zero-length vector.
      run_vec(0, 32'h40000000, 100, 100, 1'b0, 0, -1, -1);
      check("len0_done_delay", (done_cyc - start_cyc) inside {[1:2]}, 1);
      check("len0_no_out", first_ov, -1);

      // Random vectors with random valid/ready gaps and divisors.
      for (int k = 0; k < 4; k++) begin
         run_vec($urandom_range(40, 1), {1'($urandom_range(1, 0)), 8'($urandom_range(130, 126)), 23'h0},
                 60, 50, 1'b0, 0, -1, -1);
      end

      // Start while busy is ignored.
      run_vec(3, 32'h40000000, 100, 100, 1'b0, 0, 2, -1);

      // Reset mid-DRAIN with ten results outstanding, then a fresh short vector.
      run_vec(10, 32'h40000000, 100, 0, 1'b0, 0, -1, 15);
      tick();
      check("post_reset_busy", busy, 0);
      run_vec(2, 32'h3F000000, 100, 100, 1'b0, 0, -1, -1);

      // Stray divider result with nothing in flight.
      inj = 1'b1;
      tick();
      inj = 1'b0;
      tick();
      check("stray_err", err, 1);
      check("stray_no_push", out_valid, 0);
      repeat (5) tick();
      check("err_sticky", err, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
